// File: rtl/uart_frame_assembler_if.sv
// Byte-stream input and assembled-frame output bundle of the UART frame assembler.
// The DUT takes the slave view; the upstream receiver or a bench drives the master view.
interface uart_frame_assembler_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [7:0] data_1;
   logic [7:0] data_2;
   logic [7:0] data_3;
   logic       frame_valid;
   logic       frame_err;
   logic       busy;

   modport master (
      output rx_data, rx_valid,
      input  data_1, data_2, data_3, frame_valid, frame_err, busy
   );

   modport slave (
      input  rx_data, rx_valid,
      output data_1, data_2, data_3, frame_valid, frame_err, busy
   );
endinterface

// File: rtl/uart_frame_assembler.sv
// Hunts for SYNC_BYTE, collects three payload bytes and an XOR checksum, and publishes
// good frames with a one-cycle frame_valid. Bad checksums and stalls raise frame_err.
module uart_frame_assembler #(
   parameter logic [7:0] SYNC_BYTE      = 8'hA5,
   parameter int         TIMEOUT_CYCLES = 100000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   uart_frame_assembler_if.slave bus
);

   localparam int                 CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_B0,
      S_B1,
      S_B2,
      S_CHK
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [7:0]       r_sh0;
   logic [7:0]       r_sh1;
   logic [7:0]       r_sh2;
   logic [7:0]       r_d1;
   logic [7:0]       r_d2;
   logic [7:0]       r_d3;
   logic             r_fv;
   logic             r_fe;
   logic             w_fv_nxt;
   logic             w_fe_nxt;
   logic             w_load;
   logic             w_chk_ok;

   assign w_chk_ok = (bus.rx_data == (r_sh0 ^ r_sh1 ^ r_sh2));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_fv    <= 1'b0;
         r_fe    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_fv    <= w_fv_nxt;
         r_fe    <= w_fe_nxt;
      end
   end

   // A byte arriving in the expiry cycle takes priority over the timeout.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_fv_nxt    = 1'b0;
      w_fe_nxt    = 1'b0;
      w_load      = 1'b0;
      if (r_state == S_IDLE) begin
         w_cnt_nxt = '0;
         if (bus.rx_valid && (bus.rx_data == SYNC_BYTE)) begin
            w_state_nxt = S_B0;
         end
      end else if (bus.rx_valid) begin
         w_cnt_nxt = '0;
         case (r_state)
            S_B0:    w_state_nxt = S_B1;
            S_B1:    w_state_nxt = S_B2;
            S_B2:    w_state_nxt = S_CHK;
            S_CHK: begin
               w_state_nxt = S_IDLE;
               w_fv_nxt    = w_chk_ok;
               w_fe_nxt    = !w_chk_ok;
               w_load      = w_chk_ok;
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end else if (r_cnt == CNT_LAST) begin
         w_state_nxt = S_IDLE;
         w_cnt_nxt   = '0;
         w_fe_nxt    = 1'b1;
      end else begin
         w_cnt_nxt = r_cnt + 1'b1;
      end
   end

   // Shadow bytes are always written before they are read, so they carry no reset.
   always_ff @(posedge clk) begin
      if (bus.rx_valid) begin
         case (r_state)
            S_B0:    r_sh0 <= bus.rx_data;
            S_B1:    r_sh1 <= bus.rx_data;
            S_B2:    r_sh2 <= bus.rx_data;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_d1 <= 8'h00;
         r_d2 <= 8'h00;
         r_d3 <= 8'h00;
      end else if (w_load) begin
         r_d1 <= r_sh0;
         r_d2 <= r_sh1;
         r_d3 <= r_sh2;
      end
   end

   assign bus.data_1      = r_d1;
   assign bus.data_2      = r_d2;
   assign bus.data_3      = r_d3;
   assign bus.frame_valid = r_fv;
   assign bus.frame_err   = r_fe;
   assign bus.busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_frame_assembler.sv
// Directed bench for uart_frame_assembler: inputs change on the falling edge and
// outputs are read there too, half a cycle away from the active edge.
module tb_uart_frame_assembler;

   localparam int TMO = 8;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;
   int   fv_cnt;
   int   fe_cnt;
   int   fv_snap;
   int   fe_snap;

   uart_frame_assembler_if bus ();

   uart_frame_assembler #(
      .SYNC_BYTE      (8'hA5),
      .TIMEOUT_CYCLES (TMO)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.frame_valid) fv_cnt++;
      if (bus.frame_err)   fe_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
      end
   endtask

   task automatic drive(input logic [7:0] b);
      @(negedge clk);
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         bus.rx_valid = 1'b0;
      end
   endtask

   task automatic frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                        input logic [7:0] b3, input logic [7:0] b4);
      drive(b0);
      drive(b1);
      drive(b2);
      drive(b3);
      drive(b4);
   endtask

   task automatic check_data(input string tag, input logic [7:0] e1, input logic [7:0] e2,
                             input logic [7:0] e3);
      check({tag, "_d1"}, 32'(bus.data_1), 32'(e1));
      check({tag, "_d2"}, 32'(bus.data_2), 32'(e2));
      check({tag, "_d3"}, 32'(bus.data_3), 32'(e3));
   endtask

   initial begin
      n_checks     = 0;
      n_errors     = 0;
      fv_cnt       = 0;
      fe_cnt       = 0;
      rst_n        = 1'b0;
      bus.rx_data  = 8'h00;
      bus.rx_valid = 1'b0;
      repeat (3) @(negedge clk);
      check_data("rst", 8'h00, 8'h00, 8'h00);
      check("rst_fv", 32'(bus.frame_valid), 32'd0);
      check("rst_fe", 32'(bus.frame_err), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      rst_n = 1'b1;
      idle(2);

      // Good frame 11,22,33 with checksum 00
      fv_snap = fv_cnt;
      drive(8'hA5);
      check("t1_busy_pre", 32'(bus.busy), 32'd0);
      drive(8'h11);
      check("t1_busy", 32'(bus.busy), 32'd1);
      drive(8'h22);
      drive(8'h33);
      drive(8'h00);
      check("t1_fv_early", 32'(bus.frame_valid), 32'd0);
      check_data("t1_hold", 8'h00, 8'h00, 8'h00);
      idle(1);
      check("t1_fv", 32'(bus.frame_valid), 32'd1);
      check("t1_fe", 32'(bus.frame_err), 32'd0);
      check("t1_busy_end", 32'(bus.busy), 32'd0);
      check_data("t1", 8'h11, 8'h22, 8'h33);
      idle(1);
      check("t1_fv_pulse", 32'(bus.frame_valid), 32'd0);
      idle(1);
      check("t1_fv_cnt", 32'(fv_cnt - fv_snap), 32'd1);

      // Bad checksum: 01^02^03 = 00, FF sent
      fv_snap = fv_cnt;
      fe_snap = fe_cnt;
      frame(8'hA5, 8'h01, 8'h02, 8'h03, 8'hFF);
      idle(1);
      check("t3_fe", 32'(bus.frame_err), 32'd1);
      check("t3_fv", 32'(bus.frame_valid), 32'd0);
      check("t3_busy", 32'(bus.busy), 32'd0);
      check_data("t3", 8'h11, 8'h22, 8'h33);
      idle(2);
      check("t3_fe_cnt", 32'(fe_cnt - fe_snap), 32'd1);
      check("t3_fv_cnt", 32'(fv_cnt - fv_snap), 32'd0);

      // All-AA frame, checksum AA
      frame(8'hA5, 8'hAA, 8'hAA, 8'hAA, 8'hAA);
      idle(1);
      check("t2_fv", 32'(bus.frame_valid), 32'd1);
      check_data("t2", 8'hAA, 8'hAA, 8'hAA);
      idle(2);

      // Timeout after A5,01
      fe_snap = fe_cnt;
      drive(8'hA5);
      drive(8'h01);
      idle(TMO);
      check("t4_fe_early", 32'(bus.frame_err), 32'd0);
      check("t4_busy_pre", 32'(bus.busy), 32'd1);
      idle(1);
      check("t4_fe", 32'(bus.frame_err), 32'd1);
      check("t4_busy", 32'(bus.busy), 32'd0);
      check("t4_fv", 32'(bus.frame_valid), 32'd0);
      idle(1);
      check("t4_fe_pulse", 32'(bus.frame_err), 32'd0);
      check_data("t4_hold", 8'hAA, 8'hAA, 8'hAA);

      // Byte arriving in the expiry cycle wins; then 04,05,06 with checksum 07
      fe_snap = fe_cnt;
      drive(8'hA5);
      idle(TMO - 1);
      drive(8'h04);
      idle(1);
      check("t4b_fe", 32'(bus.frame_err), 32'd0);
      check("t4b_busy", 32'(bus.busy), 32'd1);
      drive(8'h05);
      drive(8'h06);
      drive(8'h07);
      idle(1);
      check("t4b_fv", 32'(bus.frame_valid), 32'd1);
      check_data("t4b", 8'h04, 8'h05, 8'h06);
      idle(2);
      check("t4b_fe_cnt", 32'(fe_cnt - fe_snap), 32'd0);

      // Garbage in IDLE, then A5 used as payload data
      fv_snap = fv_cnt;
      fe_snap = fe_cnt;
      drive(8'h00);
      drive(8'hFF);
      drive(8'h5A);
      idle(1);
      check("t5_busy", 32'(bus.busy), 32'd0);
      frame(8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5);
      idle(1);
      check("t5_fv", 32'(bus.frame_valid), 32'd1);
      check_data("t5", 8'hA5, 8'hA5, 8'hA5);
      idle(2);
      check("t5_fv_cnt", 32'(fv_cnt - fv_snap), 32'd1);
      check("t5_fe_cnt", 32'(fe_cnt - fe_snap), 32'd0);

      // Back-to-back frames at full strobe rate
      frame(8'hA5, 8'h10, 8'h20, 8'h30, 8'h00);
      drive(8'hA5);
      check("bb1_fv", 32'(bus.frame_valid), 32'd1);
      check_data("bb1", 8'h10, 8'h20, 8'h30);
      drive(8'h0F);
      drive(8'hF0);
      drive(8'h01);
      drive(8'hFE);
      idle(1);
      check("bb2_fv", 32'(bus.frame_valid), 32'd1);
      check_data("bb2", 8'h0F, 8'hF0, 8'h01);
      idle(2);

      // Reset mid-frame, then headerless bytes
      drive(8'hA5);
      drive(8'h11);
      drive(8'h22);
      idle(1);
      check("t6_busy_pre", 32'(bus.busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check_data("t6_rst", 8'h00, 8'h00, 8'h00);
      check("t6_busy", 32'(bus.busy), 32'd0);
      check("t6_fv", 32'(bus.frame_valid), 32'd0);
      idle(1);
      rst_n = 1'b1;
      fv_snap = fv_cnt;
      drive(8'h11);
      drive(8'h22);
      drive(8'h33);
      drive(8'h00);
      idle(3);
      check("t6_fv_cnt", 32'(fv_cnt - fv_snap), 32'd0);
      check("t6_busy_end", 32'(bus.busy), 32'd0);
      check_data("t6_end", 8'h00, 8'h00, 8'h00);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
